// File: rtl/apb_pwm_pkg.sv
// Shared constants and types for the APB PWM slave: register offsets, CTRL/STATUS bit
// positions and the CTRL register layout.
package apb_pwm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_DUTY   = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'hC;

    localparam int unsigned EN_BIT   = 0;
    localparam int unsigned POL_BIT  = 1;
    localparam int unsigned IE_BIT   = 2;
    localparam int unsigned DONE_BIT = 31;

    typedef enum logic [1:0] {
        REG_CTRL   = ADDR_CTRL[3:2],
        REG_PERIOD = ADDR_PERIOD[3:2],
        REG_DUTY   = ADDR_DUTY[3:2],
        REG_STATUS = ADDR_STATUS[3:2]
    } reg_sel_e;

    typedef struct packed {
        logic ie;
        logic pol;
        logic en;
    } ctrl_t;

    // Word select from a byte address; the low two bits are ignored.
    function automatic reg_sel_e reg_sel(input logic [ADDR_W-1:0] paddr);
        return reg_sel_e'(paddr[3:2]);
    endfunction

endpackage

// File: rtl/apb_pwm_if.sv
// APB3 slave-port signal bundle for the PWM block.
interface apb_pwm_if;
    import apb_pwm_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_pwm_core.sv
// PWM engine: counter, active period/duty registers loaded from shadows at each wrap or
// enable edge, and the registered compare output.
module pwm_core #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 pol,
    input  logic [CNT_WIDTH-1:0] period_shadow,
    input  logic [CNT_WIDTH-1:0] duty_shadow,
    output logic                 pwm_out,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 wrap_pulse
);

    logic                 en_q, en_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_act_q, period_act_d;
    logic [CNT_WIDTH-1:0] duty_act_q, duty_act_d;
    logic                 pwm_q, pwm_d;
    logic                 wrap_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q         <= 1'b0;
            cnt_q        <= '0;
            period_act_q <= '0;
            duty_act_q   <= '0;
            pwm_q        <= 1'b0;
        end else begin
            en_q         <= en_d;
            cnt_q        <= cnt_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            pwm_q        <= pwm_d;
        end
    end

    // Enable edge restarts the count without a wrap; a terminal count wraps and reloads.
    always_comb begin
        en_d         = en;
        cnt_d        = cnt_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        pwm_d        = pwm_q;
        wrap_c       = 1'b0;
        if (!en) begin
            cnt_d = '0;
            pwm_d = pol;
        end else begin
            pwm_d = (cnt_q < duty_act_q) ^ pol;
            if (!en_q || (cnt_q == period_act_q)) begin
                wrap_c       = en_q;
                cnt_d        = '0;
                period_act_d = period_shadow;
                duty_act_d   = duty_shadow;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign pwm_out    = pwm_q;
    assign cnt        = cnt_q;
    assign wrap_pulse = wrap_c;

endmodule

// File: rtl/apb_pwm.sv
// Zero-wait-state APB slave: CTRL/PERIOD/DUTY/STATUS register file, sticky DONE with
// W1C, level irq, and the PWM engine behind it.
module apb_pwm
    import apb_pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic     PCLK,
    input  logic     PRESET,
    apb_pwm_if.slave apb,
    output logic     pwm_out,
    output logic     irq
);

    ctrl_t                ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] duty_q, duty_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 wrap;
    logic                 wr_en;
    reg_sel_e             sel;
    logic [DATA_W-1:0]    rdata;
    logic                 unused_bits;

    assign wr_en = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign sel   = reg_sel(apb.PADDR);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_q   <= '0;
            period_q <= '0;
            duty_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            done_q   <= done_d;
        end
    end

    // Register writes; a wrap on the same edge as a DONE clear keeps DONE set.
    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        duty_d   = duty_q;
        done_d   = done_q;
        if (wr_en) begin
            unique case (sel)
                REG_CTRL: begin
                    ctrl_d.en  = apb.PWDATA[EN_BIT];
                    ctrl_d.pol = apb.PWDATA[POL_BIT];
                    ctrl_d.ie  = apb.PWDATA[IE_BIT];
                end
                REG_PERIOD: period_d = apb.PWDATA[CNT_WIDTH-1:0];
                REG_DUTY:   duty_d   = apb.PWDATA[CNT_WIDTH-1:0];
                REG_STATUS: if (apb.PWDATA[DONE_BIT]) done_d = 1'b0;
                default:    ;
            endcase
        end
        if (wrap) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (apb.PSEL) begin
            unique case (sel)
                REG_CTRL: begin
                    rdata[EN_BIT]  = ctrl_q.en;
                    rdata[POL_BIT] = ctrl_q.pol;
                    rdata[IE_BIT]  = ctrl_q.ie;
                end
                REG_PERIOD: rdata[CNT_WIDTH-1:0] = period_q;
                REG_DUTY:   rdata[CNT_WIDTH-1:0] = duty_q;
                REG_STATUS: begin
                    rdata[CNT_WIDTH-1:0] = cnt;
                    rdata[DONE_BIT]      = done_q;
                end
                default: ;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign irq         = done_q & ctrl_q.ie;

    // Address byte lanes and write bits above the field width have no storage.
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    pwm_core #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
        .clk           (PCLK),
        .rst           (PRESET),
        .en            (ctrl_q.en),
        .pol           (ctrl_q.pol),
        .period_shadow (period_q),
        .duty_shadow   (duty_q),
        .pwm_out       (pwm_out),
        .cnt           (cnt),
        .wrap_pulse    (wrap)
    );

endmodule
